// File: rtl/byte_codec_pkg.sv
// byte_codec_pkg: shared constants, state encoding and beat arithmetic for the ByteEncode/ByteDecode stream blocks
package byte_codec_pkg;
  localparam int N_COEFFS = 256;
  localparam int Q = 3329;
  localparam int D_MAX = 12;
  typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;
  // number of output beats for one polynomial encoded at width d
  function automatic int beats_per_poly(input int d, input int out_bytes);
    return N_COEFFS * d / (8 * out_bytes);
  endfunction
endpackage

// File: rtl/bit_accumulator.sv
// bit_accumulator: LSB-first bit FIFO with variable-width append and fixed-width pop
module bit_accumulator #(
  parameter int ACC_W = 80,
  parameter int IN_W = 48,
  parameter int POP_W = 32,
  parameter int FW = $clog2(ACC_W + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [FW-1:0]    i_len,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_pop,
  output logic [ACC_W-1:0] o_acc,
  output logic [FW-1:0]    o_fill
);
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_base;
  logic [FW-1:0]    r_fill;
  logic [FW-1:0]    w_base_fill;
  // pop first so a same-cycle append lands right above the surviving bits
  always_comb begin
    w_base = i_pop ? r_acc >> POP_W : r_acc;
    w_base_fill = i_pop ? r_fill - FW'(POP_W) : r_fill;
  end
  // append data is pre-masked by the producer, so bits above fill stay zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_fill <= '0;
    end else begin
      r_acc <= w_base | (i_push ? ACC_W'(i_data) << w_base_fill : '0);
      r_fill <= w_base_fill + (i_push ? i_len : '0);
    end
  end
  assign o_acc = r_acc;
  assign o_fill = r_fill;
endmodule

// File: rtl/stream_byte_encode.sv
// stream_byte_encode: streaming ByteEncode_d packer; define RANGE_CHECK_EN to flag out-of-range coefficients on err_o
module stream_byte_encode #(
  parameter int COEFFS_PER_CYCLE = 4,
  parameter int OUT_BYTES = 4,
  parameter int IN_WIDTH = 16,
  parameter int D_MAX = 12
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic [3:0]                           d_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  input  logic                                 coeff_valid_i,
  output logic                                 coeff_ready_o,
  input  logic [COEFFS_PER_CYCLE*IN_WIDTH-1:0] coeff_i,
  output logic                                 byte_valid_o,
  input  logic                                 byte_ready_i,
  output logic [OUT_BYTES*8-1:0]               byte_o,
  output logic                                 last_o,
  output logic                                 err_o
);
  import byte_codec_pkg::*;
  localparam int OW = OUT_BYTES * 8;
  localparam int PW = COEFFS_PER_CYCLE * D_MAX;
  localparam int ACC_W = OW + PW;
  localparam int FW = $clog2(ACC_W + 1);
  localparam int NB_IN = N_COEFFS / COEFFS_PER_CYCLE;
  localparam int CW = $clog2(NB_IN);
  localparam int BW = $clog2(32 * D_MAX + 1);
  state_t               r_state;
  logic [3:0]           r_d;
  logic [CW-1:0]        r_cin;
  logic [BW-1:0]        r_bout;
  logic [FW-1:0]        w_fill;
  logic [FW-1:0]        w_len;
  logic [ACC_W-1:0]     w_acc;
  logic [PW-1:0]        w_packed;
  logic [IN_WIDTH-1:0]  w_mask;
  logic                 w_start_ok;
  logic                 w_in_hs;
  logic                 w_out_hs;
  logic                 w_last_in;
  assign w_start_ok = r_state == IDLE && start_i && d_i != 4'd0 && d_i <= 4'(D_MAX);
  assign w_len = FW'(COEFFS_PER_CYCLE * int'(r_d));
  assign w_mask = ~({IN_WIDTH{1'b1}} << r_d);
  assign w_last_in = r_cin == CW'(NB_IN - 1);
  assign coeff_ready_o = r_state == FILL && w_fill <= FW'(ACC_W) - w_len;
  assign byte_valid_o = w_fill >= FW'(OW);
  assign byte_o = w_acc[OW-1:0];
  assign last_o = byte_valid_o && r_bout == BW'(beats_per_poly(int'(r_d), OUT_BYTES) - 1);
  assign w_in_hs = coeff_valid_i && coeff_ready_o;
  assign w_out_hs = byte_valid_o && byte_ready_i;
  assign busy_o = r_state == FILL || r_state == FLUSH;
  assign done_o = r_state == DONE;
  // squeeze the low d bits of each coefficient into one contiguous k*d-spaced field
  always_comb begin
    w_packed = '0;
    for (int k = 0; k < COEFFS_PER_CYCLE; k++)
      w_packed = w_packed | (PW'(coeff_i[k*IN_WIDTH +: IN_WIDTH] & w_mask) << (k * int'(r_d)));
  end
  bit_accumulator #(
    .ACC_W(ACC_W),
    .IN_W(PW),
    .POP_W(OW),
    .FW(FW)
  ) u_acc (
    .i_clk(clk_i),
    .i_rst(rst_i),
    .i_push(w_in_hs),
    .i_len(w_len),
    .i_data(w_packed),
    .i_pop(w_out_hs),
    .o_acc(w_acc),
    .o_fill(w_fill)
  );
  // sequence one polynomial: latch d on start, count input and output beats
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_d <= '0;
      r_cin <= '0;
      r_bout <= '0;
    end else begin
      if (w_start_ok) begin
        r_state <= FILL;
        r_d <= d_i;
        r_cin <= '0;
        r_bout <= '0;
      end
      if (w_in_hs) begin
        r_cin <= r_cin + CW'(1);
        if (w_last_in) r_state <= FLUSH;
      end
      if (w_out_hs) begin
        r_bout <= r_bout + BW'(1);
        if (last_o) r_state <= DONE;
      end
      if (r_state == DONE) r_state <= IDLE;
    end
  end
`ifdef RANGE_CHECK_EN
  logic                r_err;
  logic                w_bad;
  logic [IN_WIDTH:0]   w_lim;
  // d=12 coefficients live mod q, narrower widths must fit in d bits
  always_comb begin
    w_lim = r_d == 4'd12 ? (IN_WIDTH+1)'(Q) : (IN_WIDTH+1)'(1) << r_d;
    w_bad = 1'b0;
    for (int k = 0; k < COEFFS_PER_CYCLE; k++)
      w_bad = w_bad | ({1'b0, coeff_i[k*IN_WIDTH +: IN_WIDTH]} >= w_lim);
  end
  // sticky until the next accepted start
  always_ff @(posedge clk_i) begin
    if (rst_i) r_err <= 1'b0;
    else if (w_start_ok) r_err <= 1'b0;
    else if (w_in_hs && w_bad) r_err <= 1'b1;
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_stream_byte_encode.sv
// tb_stream_byte_encode: scoreboard bench for the streaming ByteEncode_d packer
module tb_stream_byte_encode;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  d_i;
  logic        busy_o;
  logic        done_o;
  logic        coeff_valid_i;
  logic        coeff_ready_o;
  logic [63:0] coeff_i;
  logic        byte_valid_o;
  logic        byte_ready_i;
  logic [31:0] byte_o;
  logic        last_o;
  logic        err_o;
`ifdef RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  int n_chk = 0;
  int n_err = 0;
  bit err_exp = 1'b0;
  logic [32:0] sb[$];

  stream_byte_encode dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_i(start_i),
    .d_i(d_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .coeff_valid_i(coeff_valid_i),
    .coeff_ready_o(coeff_ready_o),
    .coeff_i(coeff_i),
    .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i),
    .byte_o(byte_o),
    .last_o(last_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_poly(input int d, input int mode, input int stall_beat, input int abort_at);
    int f[256];
    int nb, idx, nbeat, stall_left, m_fill, lim, bp;
    logic [31:0] word, held;
    logic [32:0] e;
    bit fin, stalled, saw_low;
    for (int i = 0; i < 256; i++) begin
      f[i] = mode == 0 ? i % 2 : mode == 2 ? i % 16 : i;
      if (mode == 3 && i == 37) f[i] = 3329;
    end
    lim = d == 12 ? 3329 : 1 << d;
    nb = 8 * d;
    sb.delete();
    for (int b = 0; b < nb; b++) begin
      word = '0;
      for (int j = 0; j < 32; j++) begin
        bp = 32 * b + j;
        word[j] = ((f[bp / d] >> (bp % d)) & 1) != 0;
      end
      sb.push_back({b == nb - 1, word});
    end
    start_i = 1'b1;
    d_i = 4'(d);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    err_exp = 1'b0;
    check("busy_start", busy_o, 1);
    idx = 0;
    nbeat = 0;
    m_fill = 0;
    stall_left = 0;
    fin = 0;
    stalled = 0;
    saw_low = 0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      check("vld", byte_valid_o, m_fill >= 32);
      check("rdy", coeff_ready_o, idx < 256 && m_fill <= 80 - 4 * d);
      check("err", err_o, RC & err_exp);
      check("done_mid", done_o, 0);
      if (abort_at >= 0 && idx >= abort_at) begin
        rst_i = 1'b1;
        coeff_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        sb.delete();
        err_exp = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_vld", byte_valid_o, 0);
        repeat (3) begin
          check("abort_done", done_o, 0);
          @(posedge clk);
          #1;
        end
        return;
      end
      start_i = cyc == 5;
      if (cyc == 5) d_i = 4'd3;
      if (stall_left > 0) begin
        check("hold", byte_o, held);
        if (!coeff_ready_o) saw_low = 1;
        stall_left--;
        byte_ready_i = 1'b0;
      end else if (!stalled && stall_beat >= 0 && nbeat == stall_beat && byte_valid_o) begin
        stalled = 1;
        held = byte_o;
        stall_left = 19;
        byte_ready_i = 1'b0;
      end else byte_ready_i = 1'b1;
      coeff_valid_i = idx < 256;
      for (int k = 0; k < 4; k++) coeff_i[k*16 +: 16] = idx + k < 256 ? 16'(f[idx+k]) : 16'h0;
      #1;
      if (coeff_valid_i && coeff_ready_o) begin
        for (int k = 0; k < 4; k++) if (f[idx+k] >= lim) err_exp = 1'b1;
        idx += 4;
        m_fill += 4 * d;
      end
      if (byte_valid_o && byte_ready_i) begin
        if (sb.size() == 0) check("extra_beat", 1, 0);
        else begin
          e = sb.pop_front();
          check("byte", byte_o, e[31:0]);
          check("last", last_o, e[32]);
          if (e[32]) fin = 1;
        end
        if (d == 1) check("d1_aa", byte_o, 32'hAAAAAAAA);
        if (d == 8 && mode == 1 && nbeat == 0) check("d8_b0", byte_o, 32'h03020100);
        if (d == 8 && mode == 1 && nbeat == 63) check("d8_b63", byte_o, 32'hFFFEFDFC);
        if (d == 12 && nbeat == 0) check("d12_b0", byte_o, 32'h02001000);
        if (d == 4 && nbeat == 0) check("d4_b0", byte_o, 32'h76543210);
        nbeat++;
        m_fill -= 32;
      end
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    coeff_valid_i = 1'b0;
    byte_ready_i = 1'b1;
    if (!fin) check("timeout", 0, 1);
    check("nbeats", nbeat, nb);
    check("sb_empty", sb.size(), 0);
    if (stall_beat >= 0) begin
      check("stall_hit", stalled, 1);
      check("rdy_drop", saw_low, 1);
    end
    check("done", done_o, 1);
    check("busy_done", busy_o, 0);
    check("vld_end", byte_valid_o, 0);
    check("err_end", err_o, RC & err_exp);
    @(posedge clk);
    #1;
    check("done_pulse", done_o, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    d_i = 4'd0;
    coeff_valid_i = 1'b0;
    byte_ready_i = 1'b1;
    coeff_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rdy", coeff_ready_o, 0);
    check("rst_vld", byte_valid_o, 0);
    check("rst_byte", byte_o, 0);
    check("rst_last", last_o, 0);
    check("rst_err", err_o, 0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    run_poly(1, 0, -1, -1);
    run_poly(8, 1, -1, -1);
    run_poly(12, 1, -1, -1);
    run_poly(12, 1, 10, -1);
    run_poly(8, 1, -1, 100);
    run_poly(4, 2, -1, -1);
    run_poly(12, 3, -1, -1);
    for (int i = 0; i < 2; i++) begin
      start_i = 1'b1;
      d_i = i == 0 ? 4'd0 : 4'd13;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      check("bad_d_busy", busy_o, 0);
      check("bad_d_rdy", coeff_ready_o, 0);
      check("err_keep", err_o, RC);
    end
    run_poly(1, 0, -1, -1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
